pipe_hazard_ctrl: RTL

Central hazard controller for the 5-stage pipeline. Each cycle it sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers by generating their enable, bubble and flush controls. It resolves load-use and RAW hazards and drives the forwarding mux selects, and it freezes the pipeline while the data memory is waiting for an acknowledge. It sits beside the datapath and feeds every pipeline register and the PC.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_hazard_detect.sv | 59 +++++
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W           = 5;
    localparam int unsigned MEM_TIMEOUT_DEF = 64;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MMEM = 2'b11;

    typedef enum logic {
        RUN,
        MWAIT
    } state_t;

    // A source matches a producer only if both sides are live and r0 is never involved.
    function automatic logic reg_hit(input logic [REG_W-1:0] src, input logic use_src,
                                     input logic wreg, input logic [REG_W-1:0] dst);
        return (src != '0) && use_src && wreg && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational RAW/load-use detection and forwarding select generation.
// PIPE_HAZARD_FWD_EN selects forwarding; otherwise every match interlocks.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] drs,
    input  logic [REG_W-1:0] drt,
    input  logic             duse_rs,
    input  logic             duse_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [REG_W-1:0] erd,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [REG_W-1:0] mrd,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             stall_req
);

    logic ex_a;
    logic ex_b;
    logic mem_a;
    logic mem_b;

    assign ex_a  = reg_hit(drs, duse_rs, ewreg, erd);
    assign ex_b  = reg_hit(drt, duse_rt, ewreg, erd);
    assign mem_a = reg_hit(drs, duse_rs, mwreg, mrd);
    assign mem_b = reg_hit(drt, duse_rt, mwreg, mrd);

`ifdef PIPE_HAZARD_FWD_EN
    // Youngest producer wins; a load still in EX has no data yet and must stall.
    always_comb begin
        fwda      = FWD_RF;
        fwdb      = FWD_RF;
        stall_req = (ex_a || ex_b) && em2reg;
        if (ex_a) begin
            if (!em2reg) fwda = FWD_EX;
        end else if (mem_a) begin
            fwda = mm2reg ? FWD_MMEM : FWD_MALU;
        end
        if (ex_b) begin
            if (!em2reg) fwdb = FWD_EX;
        end else if (mem_b) begin
            fwdb = mm2reg ? FWD_MMEM : FWD_MALU;
        end
    end
`else
    logic unused_load_flags;
    assign unused_load_flags = em2reg ^ mm2reg;

    always_comb begin
        fwda      = FWD_RF;
        fwdb      = FWD_RF;
        stall_req = ex_a || ex_b || mem_a || mem_b;
    end
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: register enables/bubbles/flush, memory-wait FSM,
// timeout flag and event counters. Forwarding depends on PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] drs,
    input  logic [REG_W-1:0] drt,
    input  logic             duse_rs,
    input  logic             duse_rt,
    input  logic             dbranch_taken,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [REG_W-1:0] erd,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [REG_W-1:0] mrd,
    input  logic             mmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned      WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ARM  = WAIT_W'(MEM_TIMEOUT - 2);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              freeze;
    logic              stall_req;
    logic [1:0]        det_fwda;
    logic [1:0]        det_fwdb;

    pipe_hazard_detect u_detect (
        .drs       (drs),
        .drt       (drt),
        .duse_rs   (duse_rs),
        .duse_rt   (duse_rt),
        .ewreg     (ewreg),
        .em2reg    (em2reg),
        .erd       (erd),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mrd       (mrd),
        .fwda      (det_fwda),
        .fwdb      (det_fwdb),
        .stall_req (stall_req)
    );

    assign freeze = mmem_req && !dmem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == RUN) begin
                wait_cnt <= '0;
            end else if (state == MWAIT && freeze && wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            // The RUN cycle that raised the request counts as the first waiting cycle.
            if (state == MWAIT && freeze && wait_cnt == WAIT_ARM) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (freeze) state_next = MWAIT;
            MWAIT:   if (dmem_ack) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Priority: reset > memory freeze > load-use stall > branch flush.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        fwda         = det_fwda;
        fwdb         = det_fwdb;
        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
            fwda         = FWD_RF;
            fwdb         = FWD_RF;
        end else if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (stall_req) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (dbranch_taken) begin
            ifid_flush = 1'b1;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
